// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and its environment (block array, buttons, display).
// The slave modport is the controller side.
interface game_if #(
  parameter int N = 64
);
  logic         start;
  logic [15:0]  seed;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         btn_click;
  logic         btn_flag;
  logic [N-1:0] block_won;
  logic [N-1:0] block_lost;
  logic [N-1:0] block_flagged;
  logic [N-1:0] init_mine;
  logic         block_reset_n;
  logic         playing;
  logic [N-1:0] user_clicked;
  logic [N-1:0] user_flag;
  logic [3:0]   cursor_row;
  logic [3:0]   cursor_col;
  logic [2:0]   game_state;
  logic [9:0]   timer_sec;

  modport master (
    output start, seed, btn_up, btn_down, btn_left, btn_right, btn_click, btn_flag,
    output block_won, block_lost, block_flagged,
    input  init_mine, block_reset_n, playing, user_clicked, user_flag,
    input  cursor_row, cursor_col, game_state, timer_sec
  );

  modport slave (
    input  start, seed, btn_up, btn_down, btn_left, btn_right, btn_click, btn_flag,
    input  block_won, block_lost, block_flagged,
    output init_mine, block_reset_n, playing, user_clicked, user_flag,
    output cursor_row, cursor_col, game_state, timer_sec
  );
endinterface

// File: rtl/game_controller.sv
// Minesweeper game controller: mine placement via LFSR, cursor/button handling, win/loss FSM.
// Optional play timer enabled by defining GAME_TIMER_EN.
module game_controller #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int MINES         = 10,
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  game_if.slave bus
);

  localparam int N     = ROWS * COLS;
  localparam int EFF_M = (MINES < N - 1) ? MINES : N - 1;

  localparam int B_UP  = 5;
  localparam int B_DN  = 4;
  localparam int B_LF  = 3;
  localparam int B_RT  = 2;
  localparam int B_CLK = 1;
  localparam int B_FLG = 0;

  if (ROWS < 1 || ROWS > 16 || COLS < 1 || COLS > 16 || MINES < 0 || TICKS_PER_SEC < 1) begin : g_param_err
    $error("game_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLACE = 3'd2,
    S_PLAY  = 3'd3,
    S_WON   = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic         clr_cnt_q, clr_cnt_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [8:0]   placed_q, placed_d;
  logic [N-1:0] mine_q, mine_d;
  logic [3:0]   row_q, row_d, col_q, col_d;
  logic [1:0]   play_cnt_q, play_cnt_d;
  logic [N-1:0] clicked_q, clicked_d, flagp_q, flagp_d;
  logic         start_q;
  logic [5:0]   btn_q;

  logic [5:0]   btn_now, rise;
  logic         start_rise;
  logic [7:0]   cand, idx;
  logic         cand_hit, cand_taken, cur_flagged;

  assign btn_now    = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_click, bus.btn_flag};
  assign rise       = btn_now & ~btn_q;
  assign start_rise = bus.start & ~start_q;
  assign cand       = lfsr_q[7:0];
  assign idx        = 8'(row_q) * 8'(COLS) + 8'(col_q);

  always_comb begin
    cand_hit    = 1'b0;
    cand_taken  = 1'b0;
    cur_flagged = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (8'(i) == cand) begin
        cand_hit   = 1'b1;
        cand_taken = mine_q[i];
      end
      if (8'(i) == idx) cur_flagged = bus.block_flagged[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = 1'b0;
    lfsr_d     = lfsr_q;
    placed_d   = placed_q;
    mine_d     = mine_q;
    row_d      = row_q;
    col_d      = col_q;
    play_cnt_d = '0;
    clicked_d  = '0;
    flagp_d    = '0;
    case (state_q)
      S_IDLE: if (start_rise) state_d = S_CLEAR;
      S_CLEAR: begin
        mine_d    = '0;
        lfsr_d    = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
        placed_d  = '0;
        row_d     = '0;
        col_d     = '0;
        clr_cnt_d = ~clr_cnt_q;
        if (clr_cnt_q) state_d = S_PLACE;
      end
      S_PLACE: begin
        if (start_rise) state_d = S_CLEAR;
        else if (placed_q == 9'(EFF_M)) state_d = S_PLAY;
        else begin
          lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
          if (cand_hit && !cand_taken) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (8'(i) == cand) mine_d[i] = 1'b1;
            end
            placed_d = placed_q + 9'd1;
          end
        end
      end
      S_PLAY: begin
        if (start_rise) state_d = S_CLEAR;
        else begin
          if (rise[B_UP] && !rise[B_DN])
            row_d = (row_q == 4'd0) ? 4'(ROWS - 1) : row_q - 4'd1;
          else if (rise[B_DN] && !rise[B_UP])
            row_d = (row_q == 4'(ROWS - 1)) ? 4'd0 : row_q + 4'd1;
          if (rise[B_LF] && !rise[B_RT])
            col_d = (col_q == 4'd0) ? 4'(COLS - 1) : col_q - 4'd1;
          else if (rise[B_RT] && !rise[B_LF])
            col_d = (col_q == 4'(COLS - 1)) ? 4'd0 : col_q + 4'd1;
          // Status inputs settle for two cycles after entry; loss outranks win.
          if (play_cnt_q == 2'd2) begin
            if (|bus.block_lost)     state_d = S_LOST;
            else if (&bus.block_won) state_d = S_WON;
          end
          play_cnt_d = (play_cnt_q == 2'd2) ? 2'd2 : play_cnt_q + 2'd1;
        end
        // Pulses use the pre-move index and never leak into a non-PLAY cycle.
        if (state_d == S_PLAY) begin
          for (int unsigned i = 0; i < N; i++) begin
            clicked_d[i] = rise[B_CLK] && !cur_flagged && (8'(i) == idx);
            flagp_d[i]   = rise[B_FLG] && (8'(i) == idx);
          end
        end
      end
      S_WON, S_LOST: if (start_rise) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= 1'b0;
      lfsr_q     <= 16'hACE1;
      placed_q   <= '0;
      mine_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      play_cnt_q <= '0;
      clicked_q  <= '0;
      flagp_q    <= '0;
      start_q    <= 1'b0;
      btn_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      lfsr_q     <= lfsr_d;
      placed_q   <= placed_d;
      mine_q     <= mine_d;
      row_q      <= row_d;
      col_q      <= col_d;
      play_cnt_q <= play_cnt_d;
      clicked_q  <= clicked_d;
      flagp_q    <= flagp_d;
      start_q    <= bus.start;
      btn_q      <= btn_now;
    end
  end

`ifdef GAME_TIMER_EN
  logic [31:0] tick_q, tick_d;
  logic [9:0]  timer_q, timer_d;

  always_comb begin
    tick_d  = tick_q;
    timer_d = timer_q;
    if (state_q == S_CLEAR) begin
      tick_d  = '0;
      timer_d = '0;
    end else if (state_q == S_PLAY) begin
      if (tick_q == 32'(TICKS_PER_SEC - 1)) begin
        tick_d = '0;
        if (timer_q != 10'd999) timer_d = timer_q + 10'd1;
      end else begin
        tick_d = tick_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      timer_q <= '0;
    end else begin
      tick_q  <= tick_d;
      timer_q <= timer_d;
    end
  end

  assign bus.timer_sec = timer_q;
`else
  assign bus.timer_sec = '0;
`endif

  assign bus.init_mine     = mine_q;
  assign bus.block_reset_n = ~reset & (state_q != S_CLEAR);
  assign bus.playing       = (state_q == S_PLAY);
  assign bus.user_clicked  = clicked_q;
  assign bus.user_flag     = flagp_q;
  assign bus.cursor_row    = row_q;
  assign bus.cursor_col    = col_q;
  assign bus.game_state    = state_q;

endmodule
